// File: rtl/sensor_tx_pkg.sv
// Shared types and helpers for the 16-lane sensor link transmit framer.
package sensor_tx_pkg;
  localparam int BW         = 12;
  localparam int SYNC_WORDS = 4;

  typedef enum logic [2:0] {IDLE, SYNC_S, ACTIVE, SYNC_E, HBLANK, VBLANK} state_t;

  // Word k of a 48-bit sync code, MSB word first.
  function automatic logic [BW-1:0] sync_word(input logic [47:0] pat, input logic [1:0] k);
    return pat[(SYNC_WORDS - 1 - int'(k)) * BW +: BW];
  endfunction

  function automatic logic geom_ok(input logic [15:0] aw, ah, fw, fh);
    return (aw != '0) && (ah != '0) && ({1'b0, fw} >= {1'b0, aw} + 17'd8) && (fh >= ah);
  endfunction
endpackage

// File: rtl/sensor_tx_tpg.sv
// Ramp test pattern: lane l word = col + row + l*step, wrapping at BW bits.
module sensor_tx_tpg
  import sensor_tx_pkg::*;
#(
  parameter int D = 16
) (
  input  logic [BW-1:0]   col,
  input  logic [BW-1:0]   row,
  input  logic [BW-1:0]   step,
  output logic [D*BW-1:0] ramp
);
  for (genvar l = 0; l < D; l++) begin : g_lane
    assign ramp[l*BW +: BW] = col + row + BW'(l) * step;
  end
endmodule

// File: rtl/sensor_frame_tx.sv
// Transmit framer: sync codes, payload and blanking per lane for the sensor link.
// Optional internal ramp payload under `SENSOR_TX_TPG_EN.
module sensor_frame_tx
  import sensor_tx_pkg::*;
#(
  parameter int            D          = 16,
  parameter logic [BW-1:0] TRAIN_WORD = 12'h03A
) (
  input  logic            px_clk,
  input  logic            px_reset,
  input  logic            stream_on,
  input  logic [15:0]     ACTIVE_WIDTH,
  input  logic [15:0]     ACTIVE_HEIGHT,
  input  logic [15:0]     FRAME_WIDTH,
  input  logic [15:0]     FRAME_HEIGHT,
  input  logic [47:0]     SOF_PATTERN,
  input  logic [47:0]     SOL_PATTERN,
  input  logic [47:0]     EOL_PATTERN,
  input  logic [47:0]     EOF_PATTERN,
  input  logic            tpg_en,
  input  logic [D*BW-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [D*BW-1:0] tx_dout,
  output logic            tx_en,
  output logic            tx_vs,
  output logic            cfg_err,
  output logic            underflow,
  output logic [15:0]     frame_cnt
);
  state_t      state;
  logic [15:0] cnt, row, aw, ah, fw, fh, hb;
  logic [47:0] sof, sol, eol, eof;
  logic        stream_on_d, tpg_act;
  logic        last_row, line_end, frame_end, relatch, cfg_ok;
  logic [D*BW-1:0]        ramp, pay;
  logic [D-1:0][BW-1:0]   dout_nxt;

`ifdef SENSOR_TX_TPG_EN
  logic tpg_q;
  sensor_tx_tpg #(.D(D)) u_tpg (
    .col (cnt[BW-1:0]),
    .row (row[BW-1:0]),
    .step(BW'(1)),
    .ramp(ramp)
  );
  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset)     tpg_q <= 1'b0;
    else if (relatch) tpg_q <= tpg_en;
  end
  assign tpg_act = tpg_q;
`else
  logic tpg_unused;
  assign tpg_unused = tpg_en;
  assign ramp       = '0;
  assign tpg_act    = 1'b0;
`endif

  assign hb        = fw - aw - 16'd8;
  assign last_row  = (row == ah - 16'd1);
  assign line_end  = (state == SYNC_E && cnt == 16'(SYNC_WORDS-1) && hb == '0) ||
                     (state == HBLANK && cnt == hb - 16'd1);
  // Zero VBLANK lines closes the frame straight from the last line end.
  assign frame_end = (line_end && last_row && fh == ah) ||
                     (state == VBLANK && cnt == fw - 16'd1 && row == fh - 16'd1);
  assign relatch   = stream_on && (state == IDLE || frame_end);
  assign cfg_ok    = geom_ok(ACTIVE_WIDTH, ACTIVE_HEIGHT, FRAME_WIDTH, FRAME_HEIGHT);
  assign s_ready   = (state == ACTIVE) && !tpg_act;
  assign pay       = tpg_act ? ramp : (s_valid ? s_data : '0);

  always_comb begin
    dout_nxt = {D{TRAIN_WORD}};
    case (state)
      SYNC_S:  dout_nxt = {D{sync_word((row == '0) ? sof : sol, cnt[1:0])}};
      ACTIVE:  dout_nxt = pay;
      SYNC_E:  dout_nxt = {D{sync_word(last_row ? eof : eol, cnt[1:0])}};
      default: ;
    endcase
  end

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      tx_dout <= {D{TRAIN_WORD}};
      tx_en   <= 1'b0;
      tx_vs   <= 1'b0;
    end else begin
      tx_dout <= dout_nxt;
      tx_en   <= (state == ACTIVE);
      tx_vs   <= (state == SYNC_S) || (state == ACTIVE) || (state == SYNC_E) ||
                 (state == HBLANK && !last_row);
    end
  end

  always_ff @(posedge px_clk or posedge px_reset) begin
    if (px_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      row         <= '0;
      {aw, ah, fw, fh}       <= '0;
      {sof, sol, eol, eof}   <= '0;
      stream_on_d <= 1'b0;
      cfg_err     <= 1'b0;
      underflow   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      stream_on_d <= stream_on;
      if (stream_on && !stream_on_d) underflow <= 1'b0;
      if (state == ACTIVE && !tpg_act && !s_valid) underflow <= 1'b1;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;

      if (relatch) begin
        {aw, ah, fw, fh}     <= {ACTIVE_WIDTH, ACTIVE_HEIGHT, FRAME_WIDTH, FRAME_HEIGHT};
        {sof, sol, eol, eof} <= {SOF_PATTERN, SOL_PATTERN, EOL_PATTERN, EOF_PATTERN};
        cfg_err <= !cfg_ok;
        row     <= '0;
        cnt     <= '0;
        state   <= cfg_ok ? SYNC_S : IDLE;
      end else if (frame_end) begin
        state <= IDLE;
      end else if (line_end) begin
        row   <= row + 16'd1;
        cnt   <= '0;
        state <= last_row ? VBLANK : SYNC_S;
      end else begin
        case (state)
          SYNC_S:
            if (cnt == 16'(SYNC_WORDS-1)) begin state <= ACTIVE; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          ACTIVE:
            if (cnt == aw - 16'd1) begin state <= SYNC_E; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          SYNC_E:
            if (cnt == 16'(SYNC_WORDS-1)) begin state <= HBLANK; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          HBLANK: cnt <= cnt + 16'd1;
          VBLANK:
            if (cnt == fw - 16'd1) begin row <= row + 16'd1; cnt <= '0; end
            else cnt <= cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sensor_frame_tx.sv
// Directed + randomized bench for sensor_frame_tx with a line/column frame model.
module tb_sensor_frame_tx;
  localparam int D  = 16;
  localparam int BW = 12;
  localparam logic [11:0] TW = 12'h03A;

  logic            px_clk, px_reset, stream_on, tpg_en, s_valid, s_ready;
  logic [15:0]     ACTIVE_WIDTH, ACTIVE_HEIGHT, FRAME_WIDTH, FRAME_HEIGHT, frame_cnt;
  logic [47:0]     SOF_PATTERN, SOL_PATTERN, EOL_PATTERN, EOF_PATTERN;
  logic [D*BW-1:0] s_data, tx_dout;
  logic            tx_en, tx_vs, cfg_err, underflow;

  sensor_frame_tx dut (
    .px_clk(px_clk), .px_reset(px_reset), .stream_on(stream_on),
    .ACTIVE_WIDTH(ACTIVE_WIDTH), .ACTIVE_HEIGHT(ACTIVE_HEIGHT),
    .FRAME_WIDTH(FRAME_WIDTH), .FRAME_HEIGHT(FRAME_HEIGHT),
    .SOF_PATTERN(SOF_PATTERN), .SOL_PATTERN(SOL_PATTERN),
    .EOL_PATTERN(EOL_PATTERN), .EOF_PATTERN(EOF_PATTERN),
    .tpg_en(tpg_en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_dout(tx_dout), .tx_en(tx_en), .tx_vs(tx_vs), .cfg_err(cfg_err),
    .underflow(underflow), .frame_cnt(frame_cnt)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  int n_cmp = 0, n_err = 0;
  int g_aw, g_ah, g_fw, g_fh, en_cnt;
  logic [47:0] g_sof, g_sol, g_eol, g_eof;
  bit g_tpg = 0, g_rnd_uf = 0, m_uf = 0;
  logic [15:0] m_fc = 0;

  task automatic chk(input string tag, input logic [D*BW-1:0] obs, input logic [D*BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sw(input logic [47:0] p, input int k);
    logic [47:0] t;
    t = p >> (36 - 12 * k);
    return t[11:0];
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  task automatic drive_geom(input bit scr);
    ACTIVE_WIDTH  = 16'(g_aw + (scr ? 3 : 0));
    ACTIVE_HEIGHT = 16'(g_ah + (scr ? 1 : 0));
    FRAME_WIDTH   = 16'(g_fw + (scr ? 5 : 0));
    FRAME_HEIGHT  = 16'(g_fh + (scr ? 2 : 0));
    SOF_PATTERN = scr ? ~g_sof : g_sof;
    SOL_PATTERN = scr ? ~g_sol : g_sol;
    EOL_PATTERN = scr ? ~g_eol : g_eol;
    EOF_PATTERN = scr ? ~g_eof : g_eof;
  endtask

  task automatic set_on(input logic v);
    if (v && !stream_on) m_uf = 0;
    stream_on = v;
  endtask

  task automatic start();
    set_on(1'b1);
    @(posedge px_clk); #1;
  endtask

  // Walks one whole frame; expected words come from line/column arithmetic.
  task automatic run_frame(input bit keep_on, input int uf_row, input int uf_col);
    int n;
    n = g_fh * g_fw;
    en_cnt = 0;
    for (int i = 0; i < n; i++) begin
      int ln, c;
      bit pay, vs;
      logic [11:0] w;
      logic [D*BW-1:0] e;
      ln = i / g_fw; c = i % g_fw;
      pay = 0; w = TW;
      if (ln < g_ah) begin
        if (c < 4) w = sw((ln == 0) ? g_sof : g_sol, c);
        else if (c < 4 + g_aw) pay = 1;
        else if (c < 8 + g_aw) w = sw((ln == g_ah - 1) ? g_eof : g_eol, c - 4 - g_aw);
      end
      vs = (ln < g_ah) && !(ln == g_ah - 1 && c >= g_aw + 8);
      if (i == 0 && !keep_on) set_on(1'b0);
      if (i == 1) drive_geom(1'b1);
      if (i == n - 1) drive_geom(1'b0);
      for (int l = 0; l < D; l++) s_data[l*BW +: BW] = 12'($urandom());
      if (pay) s_valid = !(ln == uf_row && c - 4 == uf_col) && !(g_rnd_uf && $urandom_range(0, 7) == 0);
      else     s_valid = 1'($urandom());
      e = {D{w}};
      if (pay) begin
        if (g_tpg) for (int l = 0; l < D; l++) e[l*BW +: BW] = 12'((c - 4) + ln + l);
        else begin
          e = s_valid ? s_data : '0;
          if (!s_valid) m_uf = 1;
        end
      end
      #1 chk($sformatf("s_ready[%0d]", i), s_ready, pay && !g_tpg);
      @(posedge px_clk); #1;
      chk($sformatf("tx_dout[%0d]", i), tx_dout, e);
      chk($sformatf("tx_en[%0d]", i), tx_en, pay);
      chk($sformatf("tx_vs[%0d]", i), tx_vs, vs);
      if (tx_en === 1'b1) en_cnt++;
    end
    m_fc++;
    chk("frame_cnt", frame_cnt, m_fc);
    chk("underflow", underflow, m_uf);
    chk("cfg_err", cfg_err, 0);
  endtask

  task automatic idle_chk(input int k);
    for (int i = 0; i < k; i++) begin
      s_valid = 1'b1;
      chk("idle_s_ready", s_ready, 0);
      @(posedge px_clk); #1;
      chk("idle_dout", tx_dout, {D{TW}});
      chk("idle_en", tx_en, 0);
      chk("idle_vs", tx_vs, 0);
    end
  endtask

  task automatic nominal_geom();
    g_aw = 8; g_fw = 20; g_ah = 3; g_fh = 5;
    g_sof = 48'hFFF000000AB0; g_sol = rnd48(); g_eol = rnd48(); g_eof = rnd48();
    drive_geom(1'b0);
  endtask

  initial begin
    px_reset = 1'b1; stream_on = 1'b0; tpg_en = 1'b0; s_valid = 1'b0; s_data = '0;
    nominal_geom();
    @(posedge px_clk); #1;
    chk("rst_dout", tx_dout, {D{TW}});
    chk("rst_en", tx_en, 0);
    chk("rst_vs", tx_vs, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge px_clk); #1 px_reset = 1'b0;

    // nominal single frame
    start();
    run_frame(0, -1, -1);
    chk("nominal_en_cycles", en_cnt, 24);
    idle_chk(3);

    // one starved payload word at row 1 col 3
    start();
    run_frame(0, 1, 3);
    idle_chk(2);
    chk("underflow_sticky", underflow, 1);

    // rising stream_on clears underflow
    start();
    run_frame(0, -1, -1);

    // random geometry, back-to-back frames, random starvation
    g_rnd_uf = 1;
    for (int r = 0; r < 3; r++) begin
      g_aw = $urandom_range(1, 10); g_ah = $urandom_range(1, 4);
      g_fw = g_aw + 8 + $urandom_range(0, 5); g_fh = g_ah + $urandom_range(0, 2);
      g_sof = rnd48(); g_sol = rnd48(); g_eol = rnd48(); g_eof = rnd48();
      drive_geom(1'b0);
      start();
      run_frame(1, -1, -1);
      run_frame(0, -1, -1);
      idle_chk(1);
    end
    g_rnd_uf = 0;

    // asynchronous reset in the middle of ACTIVE
    nominal_geom();
    start();
    for (int k = 0; k < 7; k++) begin
      s_valid = 1'b1;
      @(posedge px_clk); #1;
    end
    chk("pre_rst_en", tx_en, 1);
    #2 px_reset = 1'b1;
    #1;
    chk("async_rst_en", tx_en, 0);
    chk("async_rst_vs", tx_vs, 0);
    chk("async_rst_dout", tx_dout, {D{TW}});
    chk("async_rst_frame_cnt", frame_cnt, 0);
    m_fc = 0; m_uf = 0;
    set_on(1'b0);
    @(posedge px_clk); #1 px_reset = 1'b0;

    // rejected geometry, then a corrected one with zero HBLANK
    g_fw = 15; drive_geom(1'b0);
    start();
    for (int k = 0; k < 2; k++) begin
      chk("bad_cfg_err", cfg_err, 1);
      chk("bad_dout", tx_dout, {D{TW}});
      chk("bad_vs", tx_vs, 0);
      chk("bad_frame_cnt", frame_cnt, 0);
      @(posedge px_clk); #1;
    end
    g_fw = 16; drive_geom(1'b0);
    @(posedge px_clk); #1;
    chk("fixed_cfg_err", cfg_err, 0);
    run_frame(0, -1, -1);
    idle_chk(1);

`ifdef SENSOR_TX_TPG_EN
    nominal_geom();
    tpg_en = 1'b1; g_tpg = 1;
    start();
    run_frame(0, -1, 3);
    tpg_en = 1'b0; g_tpg = 0;
    idle_chk(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
